instr_encoder_loader: RTL and testbench

Sequential RV32I instruction encoder and instruction-memory writer. It accepts symbolic instruction requests (kind, ALU operation, register indices, immediate) over a valid/ready handshake. Each request is packed into a 32-bit machine word, which is written to consecutive instruction-memory words. It is the inverse of the core's instruction decoder and is used by the test harness and boot path to load programs before the core is released from reset.

---
 rtl/instr_encoder_loader.sv | 183 ++++++++++++++++++
 tb/tb_instr_encoder_loader.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_encoder_loader.sv
// RV32I instruction encoder and instruction-memory writer.
// Symbolic requests are packed into 32-bit machine words. Each word is written to
// consecutive instruction-memory addresses during a load session opened by start.
module instr_encoder_loader #(
    parameter int unsigned ADDR_W    = 8,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_kind,
    input  logic [3:0]        in_alu_sel,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [31:0]       in_imm,
    input  logic              in_last,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W:0]   count
);

    localparam logic [ADDR_W-1:0] BaseAddr = BASE_ADDR[ADDR_W-1:0];

    localparam logic [6:0] OpcR    = 7'b0110011;
    localparam logic [6:0] OpcI    = 7'b0010011;
    localparam logic [6:0] OpcLoad = 7'b0000011;
    localparam logic [6:0] OpcStor = 7'b0100011;
    localparam logic [6:0] OpcBr   = 7'b1100011;
    localparam logic [6:0] OpcJal  = 7'b1101111;
    localparam logic [6:0] OpcLui  = 7'b0110111;

    typedef enum logic [1:0] {StIdle, StAccept, StWrite, StDone} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              err_q, err_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              last_q, last_d;

    logic [2:0]  f3;
    logic [6:0]  f7;
    logic        is_shift;
    logic        legal;
    logic [31:0] enc;

    // Map the decoder's ALU code onto funct3/funct7.
    always_comb begin
        f3       = 3'b000;
        f7       = 7'b0000000;
        is_shift = 1'b0;
        case (in_alu_sel)
            4'd0:    f3 = 3'b000;
            4'd1:    begin f3 = 3'b000; f7 = 7'b0100000; end
            4'd2:    begin f3 = 3'b001; is_shift = 1'b1; end
            4'd3:    f3 = 3'b010;
            4'd4:    f3 = 3'b011;
            4'd5:    f3 = 3'b100;
            4'd6:    begin f3 = 3'b101; is_shift = 1'b1; end
            4'd7:    begin f3 = 3'b101; f7 = 7'b0100000; is_shift = 1'b1; end
            4'd8:    f3 = 3'b110;
            4'd9:    f3 = 3'b111;
            default: f3 = 3'b000;
        endcase
    end

    // Pack the request into a machine word and flag requests that cannot be encoded.
    always_comb begin
        enc   = 32'h0;
        legal = 1'b1;
        case (in_kind)
            3'd0: begin
                legal = (in_alu_sel <= 4'd9);
                enc   = {f7, in_rs2, in_rs1, f3, in_rd, OpcR};
            end
            3'd1: begin
                // SUB has no immediate form.
                legal = (in_alu_sel <= 4'd9) && (in_alu_sel != 4'd1);
                if (is_shift) begin
                    enc = {f7, in_imm[4:0], in_rs1, f3, in_rd, OpcI};
                end else begin
                    enc = {in_imm[11:0], in_rs1, f3, in_rd, OpcI};
                end
            end
            3'd2: enc = {in_imm[11:0], in_rs1, 3'b010, in_rd, OpcLoad};
            3'd3: enc = {in_imm[11:5], in_rs2, in_rs1, 3'b010, in_imm[4:0], OpcStor};
            3'd4: begin
                legal = ~in_imm[0];
                enc   = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, 3'b000,
                         in_imm[4:1], in_imm[11], OpcBr};
            end
            3'd5: begin
                legal = ~in_imm[0];
                enc   = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, OpcJal};
            end
            3'd6:    enc = {in_imm[31:12], in_rd, OpcLui};
            default: legal = 1'b0;
        endcase
    end

    // Session sequencing: accept one request, write it, repeat until last or memory full.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        count_d = count_q;
        err_d   = err_q;
        wdata_d = wdata_q;
        last_d  = last_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StAccept;
                    addr_d  = BaseAddr;
                    count_d = '0;
                    err_d   = 1'b0;
                end
            end
            StAccept: begin
                if (in_valid) begin
                    last_d = in_last;
                    if (legal) begin
                        wdata_d = enc;
                        state_d = StWrite;
                    end else begin
                        err_d = 1'b1;
                        if (in_last) state_d = StDone;
                    end
                end
            end
            StWrite: begin
                addr_d  = addr_q + 1'b1;
                count_d = count_q + 1'b1;
                // The top word was just written: stop rather than wrap.
                if (addr_q == '1) begin
                    state_d = StDone;
                    if (!last_q) err_d = 1'b1;
                end else if (last_q) begin
                    state_d = StDone;
                end else begin
                    state_d = StAccept;
                end
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            addr_q  <= BaseAddr;
            count_q <= '0;
            err_q   <= 1'b0;
            wdata_q <= 32'h0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            count_q <= count_d;
            err_q   <= err_d;
            wdata_q <= wdata_d;
            last_q  <= last_d;
        end
    end

    assign in_ready   = (state_q == StAccept);
    assign imem_we    = (state_q == StWrite);
    assign busy       = (state_q != StIdle);
    assign done       = (state_q == StDone);
    assign imem_addr  = addr_q;
    assign imem_wdata = wdata_q;
    assign err        = err_q;
    assign count      = count_q;

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Directed bench for instr_encoder_loader: an 8-bit-address instance for encoding and
// session behaviour, and a 2-bit-address instance for the memory-full boundary.
module tb_instr_encoder_loader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, start2;
    logic        in_valid, in_last;
    logic [2:0]  in_kind;
    logic [3:0]  in_alu_sel;
    logic [4:0]  in_rd, in_rs1, in_rs2;
    logic [31:0] in_imm;

    logic        in_ready, imem_we, busy, done, err;
    logic [7:0]  imem_addr;
    logic [31:0] imem_wdata;
    logic [8:0]  count;

    logic        in_ready2, we2, busy2, done2, err2;
    logic [1:0]  addr2;
    logic [31:0] wdata2;
    logic [2:0]  count2;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    instr_encoder_loader #(.ADDR_W(8), .BASE_ADDR(0)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready),
        .in_kind(in_kind), .in_alu_sel(in_alu_sel), .in_rd(in_rd), .in_rs1(in_rs1),
        .in_rs2(in_rs2), .in_imm(in_imm), .in_last(in_last), .imem_we(imem_we),
        .imem_addr(imem_addr), .imem_wdata(imem_wdata), .busy(busy), .done(done),
        .err(err), .count(count)
    );

    instr_encoder_loader #(.ADDR_W(2), .BASE_ADDR(0)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .in_valid(in_valid), .in_ready(in_ready2),
        .in_kind(in_kind), .in_alu_sel(in_alu_sel), .in_rd(in_rd), .in_rs1(in_rs1),
        .in_rs2(in_rs2), .in_imm(in_imm), .in_last(in_last), .imem_we(we2),
        .imem_addr(addr2), .imem_wdata(wdata2), .busy(busy2), .done(done2),
        .err(err2), .count(count2)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    // Pulse start for one cycle on the chosen instance; returns 1 time unit after the edge.
    task automatic do_start(input bit use2);
        if (use2) start2 = 1'b1; else start = 1'b1;
        @(posedge clk); #1;
        start  = 1'b0;
        start2 = 1'b0;
    endtask

    // Offer one request and wait (bounded) for the handshake; samples the write cycle after.
    task automatic push(input bit use2, input logic [2:0] k, input logic [3:0] s,
                        input logic [4:0] d, input logic [4:0] r1, input logic [4:0] r2,
                        input logic [31:0] imm, input logic last, input int budget,
                        output bit ok, output logic we, output logic [7:0] a,
                        output logic [31:0] w, output int wcyc);
        in_kind = k; in_alu_sel = s; in_rd = d; in_rs1 = r1; in_rs2 = r2;
        in_imm = imm; in_last = last; in_valid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            if ((use2 ? in_ready2 : in_ready) === 1'b1) ok = 1'b1;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        we   = use2 ? we2 : imem_we;
        a    = use2 ? {6'b0, addr2} : imem_addr;
        w    = use2 ? wdata2 : imem_wdata;
        wcyc = cyc;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL rst_ready got=%0b exp=0", in_ready); end
        total++; if (imem_we !== 1'b0) begin bad++; $display("FAIL rst_we got=%0b exp=0", imem_we); end
        total++; if (imem_addr !== 8'h00) begin bad++; $display("FAIL rst_addr got=%0h exp=0", imem_addr); end
        total++; if (imem_wdata !== 32'h0) begin bad++; $display("FAIL rst_wdata got=%0h exp=0", imem_wdata); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%0b exp=0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL rst_done got=%0b exp=0", done); end
        total++; if (err !== 1'b0) begin bad++; $display("FAIL rst_err got=%0b exp=0", err); end
        total++; if (count !== 9'd0) begin bad++; $display("FAIL rst_count got=%0d exp=0", count); end
        rst_n = 1'b1;
        // A request with no open session must not be taken.
        in_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL idle_ready got=%0b exp=0", in_ready); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL idle_busy got=%0b exp=0", busy); end
        total++; if (imem_we !== 1'b0) begin bad++; $display("FAIL idle_we got=%0b exp=0", imem_we); end
        in_valid = 1'b0;
    endtask

    task automatic test_addi();
        bit ok; logic we; logic [7:0] a; logic [31:0] w; int wc;
        do_start(1'b0);
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL addi_ready got=%0b exp=1", in_ready); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL addi_busy got=%0b exp=1", busy); end
        push(1'b0, 3'd1, 4'd0, 5'd1, 5'd0, 5'd0, 32'd5, 1'b1, 10, ok, we, a, w, wc);
        total++; if (ok !== 1'b1) begin bad++; $display("FAIL addi_hs got=%0b exp=1", ok); end
        total++; if (we !== 1'b1) begin bad++; $display("FAIL addi_we got=%0b exp=1", we); end
        total++; if (a !== 8'h00) begin bad++; $display("FAIL addi_addr got=%0h exp=0", a); end
        total++; if (w !== 32'h00500093) begin bad++; $display("FAIL addi_data got=%08h exp=00500093", w); end
        @(negedge clk);
        total++; if ({imem_we, imem_addr, imem_wdata} !== {1'b1, 8'h00, 32'h00500093}) begin
            bad++; $display("FAIL addi_stable got=%0b/%0h/%08h exp=1/0/00500093", imem_we, imem_addr, imem_wdata);
        end
        @(posedge clk); #1;
        total++; if (done !== 1'b1) begin bad++; $display("FAIL addi_done got=%0b exp=1", done); end
        total++; if (imem_we !== 1'b0) begin bad++; $display("FAIL addi_we_off got=%0b exp=0", imem_we); end
        total++; if (count !== 9'd1) begin bad++; $display("FAIL addi_count got=%0d exp=1", count); end
        @(posedge clk); #1;
        total++; if ({done, busy} !== 2'b00) begin bad++; $display("FAIL addi_end got=%0b%0b exp=00", done, busy); end
    endtask

    task automatic test_back_to_back();
        bit ok; logic we; logic [7:0] a; logic [31:0] w; int wc, prev;
        logic [3:0]  sel_t [3];
        logic [2:0]  knd_t [3];
        logic [4:0]  rd_t  [3];
        logic [31:0] imm_t [3];
        logic [31:0] exp_t [3];
        knd_t[0] = 3'd0; sel_t[0] = 4'd0; rd_t[0] = 5'd3; imm_t[0] = 32'd0; exp_t[0] = 32'h002081B3;
        knd_t[1] = 3'd0; sel_t[1] = 4'd1; rd_t[1] = 5'd3; imm_t[1] = 32'd0; exp_t[1] = 32'h402081B3;
        knd_t[2] = 3'd1; sel_t[2] = 4'd7; rd_t[2] = 5'd4; imm_t[2] = 32'd3; exp_t[2] = 32'h4030D213;
        prev = 0;
        do_start(1'b0);
        for (int i = 0; i < 3; i++) begin
            push(1'b0, knd_t[i], sel_t[i], rd_t[i], 5'd1, 5'd2, imm_t[i], (i == 2), 10,
                 ok, we, a, w, wc);
            total++; if ({ok, we} !== 2'b11) begin bad++; $display("FAIL b2b_we[%0d] got=%0b%0b exp=11", i, ok, we); end
            total++; if (a !== 8'(i)) begin bad++; $display("FAIL b2b_addr[%0d] got=%0h exp=%0h", i, a, i); end
            total++; if (w !== exp_t[i]) begin bad++; $display("FAIL b2b_data[%0d] got=%08h exp=%08h", i, w, exp_t[i]); end
            if (i > 0) begin
                total++; if (wc - prev !== 2) begin bad++; $display("FAIL b2b_gap[%0d] got=%0d exp=2", i, wc - prev); end
            end
            prev = wc;
        end
        @(posedge clk); #1;
        total++; if ({done, count} !== {1'b1, 9'd3}) begin bad++; $display("FAIL b2b_done got=%0b/%0d exp=1/3", done, count); end
        @(posedge clk); #1;
    endtask

    task automatic test_kinds();
        bit ok; logic we; logic [7:0] a; logic [31:0] w; int wc;
        logic [2:0]  knd_t [6];
        logic [4:0]  rd_t  [6];
        logic [31:0] imm_t [6];
        logic [31:0] exp_t [6];
        knd_t[0] = 3'd3; rd_t[0] = 5'd0; imm_t[0] = 32'd8;          exp_t[0] = 32'h0020A423;
        knd_t[1] = 3'd5; rd_t[1] = 5'd1; imm_t[1] = 32'd8;          exp_t[1] = 32'h008000EF;
        knd_t[2] = 3'd6; rd_t[2] = 5'd5; imm_t[2] = 32'h12345000;   exp_t[2] = 32'h123452B7;
        knd_t[3] = 3'd4; rd_t[3] = 5'd0; imm_t[3] = 32'd16;         exp_t[3] = 32'h00208863;
        knd_t[4] = 3'd1; rd_t[4] = 5'd1; imm_t[4] = 32'hFFFFFFFF;   exp_t[4] = 32'hFFF08093;
        knd_t[5] = 3'd2; rd_t[5] = 5'd5; imm_t[5] = 32'd4;          exp_t[5] = 32'h0040A283;
        do_start(1'b0);
        for (int i = 0; i < 6; i++) begin
            push(1'b0, knd_t[i], 4'd0, rd_t[i], 5'd1, 5'd2, imm_t[i], (i == 5), 10,
                 ok, we, a, w, wc);
            total++; if ({ok, we} !== 2'b11) begin bad++; $display("FAIL kind_we[%0d] got=%0b%0b exp=11", i, ok, we); end
            total++; if (a !== 8'(i)) begin bad++; $display("FAIL kind_addr[%0d] got=%0h exp=%0h", i, a, i); end
            total++; if (w !== exp_t[i]) begin bad++; $display("FAIL kind_data[%0d] got=%08h exp=%08h", i, w, exp_t[i]); end
        end
        @(posedge clk); #1;
        total++; if ({done, count} !== {1'b1, 9'd6}) begin bad++; $display("FAIL kind_done got=%0b/%0d exp=1/6", done, count); end
        @(posedge clk); #1;
    endtask

    task automatic test_illegal();
        bit ok; logic we; logic [7:0] a; logic [31:0] w; int wc;
        do_start(1'b0);
        // I-ALU SUB, R-ALU code 10, odd branch offset: none may be written.
        push(1'b0, 3'd1, 4'd1, 5'd1, 5'd0, 5'd0, 32'd5, 1'b0, 10, ok, we, a, w, wc);
        total++; if ({ok, we} !== 2'b10) begin bad++; $display("FAIL ill_subi got=%0b%0b exp=10", ok, we); end
        total++; if (err !== 1'b1) begin bad++; $display("FAIL ill_err got=%0b exp=1", err); end
        total++; if (imem_addr !== 8'h00) begin bad++; $display("FAIL ill_addr got=%0h exp=0", imem_addr); end
        push(1'b0, 3'd0, 4'd10, 5'd1, 5'd1, 5'd2, 32'd0, 1'b0, 10, ok, we, a, w, wc);
        total++; if ({ok, we} !== 2'b10) begin bad++; $display("FAIL ill_rsel got=%0b%0b exp=10", ok, we); end
        push(1'b0, 3'd4, 4'd0, 5'd0, 5'd1, 5'd2, 32'd3, 1'b0, 10, ok, we, a, w, wc);
        total++; if ({ok, we} !== 2'b10) begin bad++; $display("FAIL ill_beq got=%0b%0b exp=10", ok, we); end
        // start while busy must not restart the session or clear err.
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        total++; if ({err, in_ready} !== 2'b11) begin bad++; $display("FAIL ill_busy_start got=%0b%0b exp=11", err, in_ready); end
        push(1'b0, 3'd1, 4'd0, 5'd1, 5'd0, 5'd0, 32'd5, 1'b1, 10, ok, we, a, w, wc);
        total++; if ({ok, we} !== 2'b11) begin bad++; $display("FAIL ill_legal_we got=%0b%0b exp=11", ok, we); end
        total++; if (a !== 8'h00) begin bad++; $display("FAIL ill_legal_addr got=%0h exp=0", a); end
        total++; if (w !== 32'h00500093) begin bad++; $display("FAIL ill_legal_data got=%08h exp=00500093", w); end
        @(posedge clk); #1;
        total++; if ({done, err, count} !== {2'b11, 9'd1}) begin
            bad++; $display("FAIL ill_done got=%0b/%0b/%0d exp=1/1/1", done, err, count);
        end
        @(posedge clk); #1;
        do_start(1'b0);
        total++; if (err !== 1'b0) begin bad++; $display("FAIL ill_err_clr got=%0b exp=0", err); end
        // An illegal final request ends the session without a write.
        push(1'b0, 3'd7, 4'd0, 5'd0, 5'd0, 5'd0, 32'd0, 1'b1, 10, ok, we, a, w, wc);
        total++; if ({ok, we, done, err} !== 4'b1011) begin
            bad++; $display("FAIL ill_last got=%0b%0b%0b%0b exp=1011", ok, we, done, err);
        end
        total++; if (count !== 9'd0) begin bad++; $display("FAIL ill_last_count got=%0d exp=0", count); end
        @(posedge clk); #1;
    endtask

    task automatic test_full();
        bit ok; logic we; logic [7:0] a; logic [31:0] w; int wc;
        logic [31:0] exp_w;
        do_start(1'b1);
        for (int i = 0; i < 4; i++) begin
            push(1'b1, 3'd1, 4'd0, 5'(i + 1), 5'd0, 5'd0, 32'(i), 1'b0, 10, ok, we, a, w, wc);
            exp_w = {12'(i), 5'd0, 3'b000, 5'(i + 1), 7'b0010011};
            total++; if ({ok, we} !== 2'b11) begin bad++; $display("FAIL full_we[%0d] got=%0b%0b exp=11", i, ok, we); end
            total++; if (a !== 8'(i)) begin bad++; $display("FAIL full_addr[%0d] got=%0h exp=%0h", i, a, i); end
            total++; if (w !== exp_w) begin bad++; $display("FAIL full_data[%0d] got=%08h exp=%08h", i, w, exp_w); end
        end
        @(posedge clk); #1;
        total++; if ({done2, err2, count2} !== {2'b11, 3'd4}) begin
            bad++; $display("FAIL full_done got=%0b/%0b/%0d exp=1/1/4", done2, err2, count2);
        end
        // The fifth request must never be accepted once the session has ended.
        push(1'b1, 3'd1, 4'd0, 5'd9, 5'd0, 5'd0, 32'd4, 1'b1, 6, ok, we, a, w, wc);
        total++; if (ok !== 1'b0) begin bad++; $display("FAIL full_fifth got=%0b exp=0", ok); end
        total++; if ({busy2, we2} !== 2'b00) begin bad++; $display("FAIL full_idle got=%0b%0b exp=00", busy2, we2); end
    endtask

    task automatic test_reset_mid();
        bit ok; logic we; logic [7:0] a; logic [31:0] w; int wc;
        do_start(1'b0);
        push(1'b0, 3'd1, 4'd0, 5'd1, 5'd0, 5'd0, 32'd5, 1'b0, 10, ok, we, a, w, wc);
        push(1'b0, 3'd1, 4'd0, 5'd1, 5'd0, 5'd0, 32'd6, 1'b0, 10, ok, we, a, w, wc);
        total++; if ({ok, we, a} !== {2'b11, 8'h01}) begin bad++; $display("FAIL mid_pre got=%0b%0b/%0h exp=11/1", ok, we, a); end
        #2 rst_n = 1'b0;
        #1;
        total++; if (imem_we !== 1'b0) begin bad++; $display("FAIL mid_we got=%0b exp=0", imem_we); end
        total++; if ({in_ready, busy, done, err} !== 4'b0000) begin
            bad++; $display("FAIL mid_ctl got=%0b%0b%0b%0b exp=0000", in_ready, busy, done, err);
        end
        total++; if ({imem_addr, imem_wdata, count} !== {8'h00, 32'h0, 9'd0}) begin
            bad++; $display("FAIL mid_data got=%0h/%08h/%0d exp=0/0/0", imem_addr, imem_wdata, count);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        do_start(1'b0);
        push(1'b0, 3'd1, 4'd0, 5'd2, 5'd0, 5'd0, 32'd7, 1'b1, 10, ok, we, a, w, wc);
        total++; if ({ok, we, a} !== {2'b11, 8'h00}) begin bad++; $display("FAIL mid_restart got=%0b%0b/%0h exp=11/0", ok, we, a); end
        total++; if (w !== 32'h00700113) begin bad++; $display("FAIL mid_restart_data got=%08h exp=00700113", w); end
        @(posedge clk); #1;
        total++; if ({done, count} !== {1'b1, 9'd1}) begin bad++; $display("FAIL mid_done got=%0b/%0d exp=1/1", done, count); end
        @(posedge clk); #1;
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; start2 = 1'b0; in_valid = 1'b0; in_last = 1'b0;
        in_kind = 3'd0; in_alu_sel = 4'd0; in_rd = 5'd0; in_rs1 = 5'd0; in_rs2 = 5'd0;
        in_imm = 32'h0;
        test_reset();
        test_addi();
        test_back_to_back();
        test_kinds();
        test_illegal();
        test_full();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
